// File: rtl/uart_lcd_char_router.sv
// Routes bytes popped from the UART RX FIFO to the LCD1602 driver. Printable
// characters and backspace are sent as an address command followed by a data
// write. CR, LF and FF adjust the cursor, and FF also clears the display.
// Every decoded byte is optionally echoed to the UART TX.
//
// Ports:
//   clk_50MHz            system clock
//   reset                asynchronous active-low reset
//   fifo_empty           RX FIFO empty flag
//   fifo_rd_data[7:0]    RX FIFO head byte
//   fifo_rd              one-cycle pop strobe
//   lcd_valid/lcd_ready  LCD transfer handshake
//   lcd_rs               0 = command, 1 = data
//   lcd_data[7:0]        command or character byte
//   echo_valid/ready     TX echo handshake
//   echo_data[7:0]       echoed byte
//   cursor_row           current line
//   cursor_col[3:0]      current column
module uart_lcd_char_router #(
  parameter int unsigned COLS    = 16,
  parameter bit          ECHO_EN = 1'b1
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd,
  output logic       lcd_valid,
  input  logic       lcd_ready,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       echo_valid,
  input  logic       echo_ready,
  output logic [7:0] echo_data,
  output logic       cursor_row,
  output logic [3:0] cursor_col
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, CHAR, CLEAR, ECHO} state_t;

  state_t        state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          row_d;
  logic [CW-1:0] col_d;
  logic          fifo_rd_d, lcd_valid_d, lcd_rs_d, echo_valid_d;
  logic [7:0]    lcd_data_d, echo_data_d;
  logic          lcd_done;
  logic          is_print;
  logic          adv_row, back_row;
  logic [CW-1:0] adv_col, back_col;

  assign is_print = (fifo_rd_data >= 8'h20) && (fifo_rd_data <= 8'h7E);

  // Cursor one position forward, wrapping line 1 back to line 0
  always_comb begin
    if (cursor_col == LAST_COL) begin
      adv_col = '0;
      adv_row = ~cursor_row;
    end else begin
      adv_col = cursor_col + CW'(1);
      adv_row = cursor_row;
    end
  end

  // Cursor one position back; the home position does not move
  always_comb begin
    back_row = cursor_row;
    back_col = cursor_col;
    if (cursor_col != '0) begin
      back_col = cursor_col - CW'(1);
    end else if (cursor_row) begin
      back_row = 1'b0;
      back_col = LAST_COL;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      fifo_rd    <= 1'b0;
      lcd_valid  <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= '0;
      echo_valid <= 1'b0;
      echo_data  <= '0;
      cursor_row <= 1'b0;
      cursor_col <= '0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      fifo_rd    <= fifo_rd_d;
      lcd_valid  <= lcd_valid_d;
      lcd_rs     <= lcd_rs_d;
      lcd_data   <= lcd_data_d;
      echo_valid <= echo_valid_d;
      echo_data  <= echo_data_d;
      cursor_row <= row_d;
      cursor_col <= col_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    row_d        = cursor_row;
    col_d        = cursor_col;
    fifo_rd_d    = 1'b0;
    lcd_valid_d  = lcd_valid;
    lcd_rs_d     = lcd_rs;
    lcd_data_d   = lcd_data;
    echo_valid_d = echo_valid;
    echo_data_d  = echo_data;
    lcd_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_rd) begin
          fifo_rd_d = !fifo_empty;
        end else begin
          // Pop cycle: capture and decode the head byte
          byte_d      = fifo_rd_data;
          echo_data_d = fifo_rd_data;
          if (is_print) begin
            state_d     = ADDR;
            lcd_valid_d = 1'b1;
            lcd_rs_d    = 1'b0;
            lcd_data_d  = {1'b1, cursor_row, 2'b00, cursor_col};
          end else begin
            case (fifo_rd_data)
              8'h08: begin
                state_d     = ADDR;
                lcd_valid_d = 1'b1;
                lcd_rs_d    = 1'b0;
                lcd_data_d  = {1'b1, back_row, 2'b00, back_col};
              end
              8'h0C: begin
                state_d     = CLEAR;
                lcd_valid_d = 1'b1;
                lcd_rs_d    = 1'b0;
                lcd_data_d  = 8'h01;
              end
              8'h0D: begin
                col_d = '0;
                if (ECHO_EN) begin
                  state_d      = ECHO;
                  echo_valid_d = 1'b1;
                end
              end
              8'h0A: begin
                row_d = ~cursor_row;
                if (ECHO_EN) begin
                  state_d      = ECHO;
                  echo_valid_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      ADDR: begin
        if (lcd_ready) begin
          state_d    = CHAR;
          lcd_rs_d   = 1'b1;
          lcd_data_d = (byte_q == 8'h08) ? 8'h20 : byte_q;
        end
      end
      CHAR: begin
        if (lcd_ready) begin
          lcd_done = 1'b1;
          if (byte_q == 8'h08) begin
            row_d = back_row;
            col_d = back_col;
          end else begin
            row_d = adv_row;
            col_d = adv_col;
          end
        end
      end
      CLEAR: begin
        if (lcd_ready) begin
          lcd_done = 1'b1;
          row_d    = 1'b0;
          col_d    = '0;
        end
      end
      ECHO: begin
        if (echo_ready) begin
          state_d      = IDLE;
          echo_valid_d = 1'b0;
          // FIFO cannot have drained since the last pop, so pop right away
          fifo_rd_d    = !fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase

    // Last LCD transfer of the byte: move to echo or straight back to idle
    if (lcd_done) begin
      lcd_valid_d = 1'b0;
      if (ECHO_EN) begin
        state_d      = ECHO;
        echo_valid_d = 1'b1;
      end else begin
        state_d   = IDLE;
        fifo_rd_d = !fifo_empty;
      end
    end
  end

endmodule

// File: doc/uart_lcd_char_router.md
# uart_lcd_char_router

Byte-to-display router between the UART receive FIFO and the LCD1602 driver. Pops one received byte at a time and decodes printable ASCII and a small set of control characters. Each printable byte becomes cursor-addressed LCD command/data transfers. The accepted byte is then handed to the UART transmitter as an echo. The block tracks a 2-line cursor with wrap-around, so the terminal and the LCD stay consistent.

## Interface
- COLS, 16, characters per LCD line; legal range 1..16.
- ECHO_EN, 1, 1 = echo accepted bytes to TX; 0 = skip the echo phase.

- clk_50MHz  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  RX FIFO empty flag.
- fifo_rd_data  in  8  RX FIFO head byte; valid whenever fifo_empty=0.
- fifo_rd  out  1  one-cycle pop strobe.
- lcd_valid  out  1  LCD transfer request.
- lcd_ready  in  1  LCD driver can accept; a transfer completes when lcd_valid & lcd_ready.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_data  out  8  command or character byte.
- echo_valid  out  1  echo byte request.
- echo_ready  in  1  TX accepts; a transfer completes when echo_valid & echo_ready.
- echo_data  out  8  echoed byte.
- cursor_row  out  1  current line (0/1).
- cursor_col  out  4  current column, 0..COLS-1.

## Operation
- FSM states: IDLE, ADDR, CHAR, CLEAR, ECHO.
- IDLE, fifo_empty=0:
  - assert fifo_rd for one cycle;
  - capture fifo_rd_data into a byte register in that same cycle;
  - decode and move to the next state.
- Printable (0x20..0x7E):
  - ADDR sends lcd_rs=0, lcd_data=0x80|addr.
  - addr = (row ? 0x40 : 0x00) + col.
  - CHAR sends lcd_rs=1, lcd_data=byte.
  - Cursor advances: col+1. At col=COLS-1: col=0 and row toggles, so row1 wraps to row0.
- 0x08 backspace:
  - Cursor retreats first: col-1. At col=0,row=1 → row0, col COLS-1. At col=0,row=0 → no move.
  - ADDR at the new position, then CHAR with 0x20.
  - Cursor stays at the new position afterwards.
- 0x0D CR: col=0; no LCD transfer.
- 0x0A LF: row toggles, col unchanged; no LCD transfer.
- 0x0C FF: CLEAR sends lcd_rs=0, lcd_data=0x01; then row=col=0.
- Any other byte: popped and discarded; no LCD transfer, no echo; back to IDLE.
- ECHO (when ECHO_EN=1, for every decoded byte):
  - echo_data = the original byte (0x08 echoes 0x08).
  - Hold echo_valid until the handshake completes.
  - With ECHO_EN=0, go straight to IDLE.
- At most one byte is in flight; no pop occurs until that byte's echo completes.
- The cursor updates in the cycle of the last LCD handshake for that byte, or in the decode cycle when the byte has no LCD transfer.

## Timing
- Reset values: every output 0; row=col=0; state IDLE. Reset is asynchronous: asserting it mid-transfer drops lcd_valid and echo_valid immediately, and the byte in flight is lost.
- Pop in cycle T → first lcd_valid (or echo_valid, if the byte has no LCD transfer) in cycle T+1.
- The next request is asserted in the cycle after the previous handshake, never in the same cycle.
- While valid=1 and ready=0, lcd_rs, lcd_data and echo_data hold stable; valid is never withdrawn.
- After the echo handshake, IDLE comes next cycle; a pop is possible in that cycle.
- Minimum printable-byte cost with ready tied high: 1 (pop) + 2 (LCD transfers) + 1 (echo) = 4 cycles.
- lcd_ready or echo_ready high while the matching valid is low has no effect.
- Back-to-back pops are impossible; fifo_rd is never asserted while fifo_empty=1.

## Test plan
- Reset, push 0x31, all readies high:
  - one fifo_rd pulse;
  - LCD (0,0x80) then (1,0x31);
  - echo 0x31;
  - cursor 0/1;
  - repeat with 0x32, 0x33 → addresses 0x81, 0x82.
- 17 × 'A':
  - 17th addressed with 0xC0, cursor 1/1;
  - after 32 chars the 33rd is addressed 0x80 (wrap).
- Backpressure:
  - hold lcd_ready=0 for 100 cycles during ADDR, with more bytes queued → lcd_valid/rs/data stable, no further fifo_rd;
  - hold echo_ready=0 the same way → same stability, no pop.
- Cursor at row1,col0, send 0x08 → (0,0x8F), (1,0x20), cursor 0/15, echo 0x08. Then 0x0D → col 0, no LCD transfer. Then 0x0A → row 1.
- Send 0x0C → single transfer (0,0x01), cursor 0/0. Send 0x07 → popped, no lcd_valid, no echo_valid.
- Assert reset while lcd_valid=1 → all outputs 0 at once. After release, with the FIFO nonempty, a fresh pop occurs and starts at address 0x80.
